vx_scoreboard: RTL and testbench

//  Issue-stage RAW/WAW hazard check between the instruction buffer and dispatch.

---
 rtl/vx_scoreboard_pkg.sv | 27 ++
 rtl/vx_scoreboard_if.sv | 44 ++++
 rtl/vx_scoreboard_bank.sv | 51 +++++
 rtl/vx_scoreboard.sv | 89 ++++++++
 tb/tb_vx_scoreboard.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/vx_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vx_scoreboard_pkg
// Description : Shared widths and issue-tuple type for the issue-stage scoreboard.
// Revision    : 1.0
// ============================================================================
package vx_scoreboard_pkg;

  localparam int NUM_WARPS = 4;
  localparam int NUM_REGS  = 64;
  localparam int NW_BITS   = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
  localparam int NR_BITS   = $clog2(NUM_REGS);

  typedef logic [NW_BITS-1:0] wid_t;
  typedef logic [NR_BITS-1:0] reg_t;

  // Shared with the instruction buffer so both agree on field order.
  typedef struct packed {
    wid_t wid;
    reg_t rd;
    reg_t rs1;
    reg_t rs2;
    reg_t rs3;
  } issue_tuple_t;

endpackage
`default_nettype wire

// File: rtl/vx_scoreboard_if.sv
`default_nettype none
// ============================================================================
// Module      : vx_scoreboard_if
// Description : Instruction-buffer head, lookahead and writeback bundle.
// Revision    : 1.0
// ============================================================================
interface vx_scoreboard_if;
  import vx_scoreboard_pkg::*;

  logic ibuf_valid;
  wid_t ibuf_wid;
  logic ibuf_wb;
  reg_t ibuf_rd;
  reg_t ibuf_rs1;
  reg_t ibuf_rs2;
  reg_t ibuf_rs3;
  wid_t ibuf_wid_n;
  reg_t ibuf_rd_n;
  reg_t ibuf_rs1_n;
  reg_t ibuf_rs2_n;
  reg_t ibuf_rs3_n;
  logic ibuf_ready;
  logic wb_valid;
  wid_t wb_wid;
  reg_t wb_rd;
  logic wb_eop;
  logic release_err;

  modport master (
    output ibuf_valid, ibuf_wid, ibuf_wb, ibuf_rd, ibuf_rs1, ibuf_rs2, ibuf_rs3,
    output ibuf_wid_n, ibuf_rd_n, ibuf_rs1_n, ibuf_rs2_n, ibuf_rs3_n,
    output wb_valid, wb_wid, wb_rd, wb_eop,
    input  ibuf_ready, release_err
  );

  modport slave (
    input  ibuf_valid, ibuf_wid, ibuf_wb, ibuf_rd, ibuf_rs1, ibuf_rs2, ibuf_rs3,
    input  ibuf_wid_n, ibuf_rd_n, ibuf_rs1_n, ibuf_rs2_n, ibuf_rs3_n,
    input  wb_valid, wb_wid, wb_rd, wb_eop,
    output ibuf_ready, release_err
  );

endinterface
`default_nettype wire

// File: rtl/vx_scoreboard_bank.sv
`default_nettype none
// ============================================================================
// Module      : vx_scoreboard_bank
// Description : One warp's in-use register vector with set/clear and 4 lookups.
// Revision    : 1.0
// ============================================================================
module vx_scoreboard_bank #(
  parameter int NUM_REGS = 64,
  parameter int NR_BITS  = $clog2(NUM_REGS)
) (
  input  wire logic                    clk,
  input  wire logic                    reset,
  input  wire logic                    i_set_en,
  input  wire logic [NR_BITS-1:0]      i_set_idx,
  input  wire logic                    i_clr_en,
  input  wire logic [NR_BITS-1:0]      i_clr_idx,
  input  wire logic [3:0][NR_BITS-1:0] i_rd_idx,
  output logic [3:0]                   o_rd_next,
  output logic                         o_clr_hit
);

  logic [NUM_REGS-1:0] r_inuse;
  logic [NUM_REGS-1:0] w_set_mask;
  logic [NUM_REGS-1:0] w_clr_mask;
  logic [NUM_REGS-1:0] w_inuse_n;

  always_comb begin
    w_set_mask = '0;
    w_clr_mask = '0;
    if (i_set_en) w_set_mask[i_set_idx] = 1'b1;
    if (i_clr_en) w_clr_mask[i_clr_idx] = 1'b1;
  end

  // Clear first, then set: a same-edge set belongs to the younger write.
  assign w_inuse_n = (r_inuse & ~w_clr_mask) | w_set_mask;

  always_ff @(posedge clk) begin
    if (reset) r_inuse <= '0;
    else       r_inuse <= w_inuse_n;
  end

  generate
    for (genvar k = 0; k < 4; k++) begin : g_lookup
      assign o_rd_next[k] = w_inuse_n[i_rd_idx[k]];
    end
  endgenerate

  assign o_clr_hit = r_inuse[i_clr_idx];

endmodule
`default_nettype wire

// File: rtl/vx_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : vx_scoreboard
// Description : Per-warp RAW/WAW issue scoreboard with a registered stall.
// Revision    : 1.0
// ============================================================================
module vx_scoreboard
  import vx_scoreboard_pkg::*;
(
  input  wire logic       clk,
  input  wire logic       reset,
  vx_scoreboard_if.slave  bus
);

  issue_tuple_t         w_look;
  logic                 w_issue;
  logic                 w_release;
  logic                 w_same_entry;
  logic                 w_rel_hit;
  logic                 w_rel_wid_ok;
  logic                 w_rel_err;
  logic                 w_deps_n;
  logic [NUM_WARPS-1:0] w_bank_dep;
  logic [NUM_WARPS-1:0] w_bank_hit;
  logic                 r_deps;
  logic                 r_release_err;

  assign w_look = '{wid: bus.ibuf_wid_n, rd: bus.ibuf_rd_n, rs1: bus.ibuf_rs1_n,
                    rs2: bus.ibuf_rs2_n, rs3: bus.ibuf_rs3_n};

  // x0 is hardwired zero, so it never becomes a dependency.
  assign w_issue      = bus.ibuf_valid & ~r_deps & bus.ibuf_wb & (bus.ibuf_rd != '0);
  assign w_release    = bus.wb_valid & bus.wb_eop;
  assign w_same_entry = w_issue & (bus.ibuf_wid == bus.wb_wid) & (bus.ibuf_rd == bus.wb_rd);

  generate
    for (genvar g = 0; g < NUM_WARPS; g++) begin : g_bank
      logic [3:0] w_rd_next;

      vx_scoreboard_bank #(
        .NUM_REGS (NUM_REGS),
        .NR_BITS  (NR_BITS)
      ) u_bank (
        .clk       (clk),
        .reset     (reset),
        .i_set_en  (w_issue & (bus.ibuf_wid == wid_t'(g))),
        .i_set_idx (bus.ibuf_rd),
        .i_clr_en  (w_release & (bus.wb_wid == wid_t'(g))),
        .i_clr_idx (bus.wb_rd),
        .i_rd_idx  ({w_look.rd, w_look.rs1, w_look.rs2, w_look.rs3}),
        .o_rd_next (w_rd_next),
        .o_clr_hit (w_bank_hit[g])
      );

      assign w_bank_dep[g] = |w_rd_next;
    end
  endgenerate

  // Exact-width warp match; an out-of-range id selects nothing.
  always_comb begin
    w_deps_n     = 1'b0;
    w_rel_hit    = 1'b0;
    w_rel_wid_ok = 1'b0;
    for (int g = 0; g < NUM_WARPS; g++) begin
      if (w_look.wid == wid_t'(g)) w_deps_n = w_bank_dep[g];
      if (bus.wb_wid == wid_t'(g)) begin
        w_rel_hit    = w_bank_hit[g];
        w_rel_wid_ok = 1'b1;
      end
    end
  end

  assign w_rel_err = w_release & w_rel_wid_ok & ~w_rel_hit & ~w_same_entry;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_deps        <= 1'b0;
      r_release_err <= 1'b0;
    end else begin
      r_deps        <= w_deps_n;
      r_release_err <= r_release_err | w_rel_err;
    end
  end

  assign bus.ibuf_ready  = ~r_deps;
  assign bus.release_err = r_release_err;

endmodule
`default_nettype wire

// File: tb/tb_vx_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_vx_scoreboard
// Description : Self-checking bench for vx_scoreboard with a reference table model.
// Revision    : 1.0
// ============================================================================
module tb_vx_scoreboard;
  import vx_scoreboard_pkg::*;

  typedef struct packed {
    logic valid;
    wid_t wid;
    logic wb;
    reg_t rd;
    reg_t rs1;
    reg_t rs2;
    reg_t rs3;
  } instr_t;

  typedef struct packed {
    logic ready;
    logic err;
  } exp_t;

  localparam instr_t c_IDLE = '0;

  logic clk;
  logic reset;

  vx_scoreboard_if sb_if ();

  vx_scoreboard dut (
    .clk   (clk),
    .reset (reset),
    .bus   (sb_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  instr_t cur;
  instr_t prog[$];
  exp_t   exp_q[$];
  string  phase;

  logic [NUM_REGS-1:0] m_tab [NUM_WARPS];
  logic                m_ready;
  logic                m_err;

  property p_lookahead;
    @(posedge clk) disable iff (reset)
      sb_if.ibuf_wid == $past(sb_if.ibuf_wid_n) && sb_if.ibuf_rd == $past(sb_if.ibuf_rd_n) &&
      sb_if.ibuf_rs1 == $past(sb_if.ibuf_rs1_n) && sb_if.ibuf_rs2 == $past(sb_if.ibuf_rs2_n) &&
      sb_if.ibuf_rs3 == $past(sb_if.ibuf_rs3_n);
  endproperty
  a_lookahead: assert property (p_lookahead)
    else $error("FAIL lookahead: head fields differ from previous lookahead");

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s/%s: got=%0h expected=%0h t=%0t", phase, tag, got, exp, $time);
    end
  endtask

  function automatic instr_t mk(input int wid, input int wb, input int rd,
                                input int rs1, input int rs2, input int rs3);
    instr_t t;
    t.valid = 1'b1;
    t.wid   = wid_t'(wid);
    t.wb    = wb[0];
    t.rd    = reg_t'(rd);
    t.rs1   = reg_t'(rs1);
    t.rs2   = reg_t'(rs2);
    t.rs3   = reg_t'(rs3);
    return t;
  endfunction

  // One clock: drive head/lookahead/writeback, update the model, check after the edge.
  task automatic cycle(input logic rst_i, input logic wv, input int ww, input int wr, input logic we);
    instr_t nxt;
    exp_t   e;
    logic   iss, set, rel, same;
    wid_t   w_w;
    reg_t   w_r;
    w_w = wid_t'(ww);
    w_r = reg_t'(wr);
    iss = cur.valid && m_ready && !rst_i;
    if (rst_i)                   nxt = cur;
    else if (!cur.valid || iss)  nxt = (prog.size() > 0) ? prog.pop_front() : c_IDLE;
    else                         nxt = cur;

    reset            = rst_i;
    sb_if.ibuf_valid = cur.valid;
    sb_if.ibuf_wid   = cur.wid;
    sb_if.ibuf_wb    = cur.wb;
    sb_if.ibuf_rd    = cur.rd;
    sb_if.ibuf_rs1   = cur.rs1;
    sb_if.ibuf_rs2   = cur.rs2;
    sb_if.ibuf_rs3   = cur.rs3;
    sb_if.ibuf_wid_n = nxt.wid;
    sb_if.ibuf_rd_n  = nxt.rd;
    sb_if.ibuf_rs1_n = nxt.rs1;
    sb_if.ibuf_rs2_n = nxt.rs2;
    sb_if.ibuf_rs3_n = nxt.rs3;
    sb_if.wb_valid   = wv;
    sb_if.wb_wid     = w_w;
    sb_if.wb_rd      = w_r;
    sb_if.wb_eop     = we;

    set  = iss && cur.wb && (cur.rd != '0);
    rel  = wv && we;
    same = set && (cur.wid == w_w) && (cur.rd == w_r);
    if (rst_i) begin
      for (int w = 0; w < NUM_WARPS; w++) m_tab[w] = '0;
      m_err   = 1'b0;
      m_ready = 1'b1;
    end else begin
      if (rel && !m_tab[w_w][w_r] && !same) m_err = 1'b1;
      if (rel) m_tab[w_w][w_r] = 1'b0;
      if (set) m_tab[cur.wid][cur.rd] = 1'b1;
      m_ready = !(m_tab[nxt.wid][nxt.rd] | m_tab[nxt.wid][nxt.rs1] |
                  m_tab[nxt.wid][nxt.rs2] | m_tab[nxt.wid][nxt.rs3]);
    end
    exp_q.push_back('{ready: m_ready, err: m_err});

    @(posedge clk);
    #1;
    cur = nxt;
    e = exp_q.pop_front();
    chk("ibuf_ready", {31'd0, sb_if.ibuf_ready}, {31'd0, e.ready});
    chk("release_err", {31'd0, sb_if.release_err}, {31'd0, e.err});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 0, 0, 1'b0);
  endtask

  initial begin
    cur     = c_IDLE;
    m_ready = 1'b1;
    m_err   = 1'b0;
    for (int w = 0; w < NUM_WARPS; w++) m_tab[w] = '0;

    phase = "reset";
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 0, 0, 1'b0);
    chk("rst_ready", {31'd0, sb_if.ibuf_ready}, 32'd1);
    chk("rst_err", {31'd0, sb_if.release_err}, 32'd0);

    phase = "raw_stall";
    prog.push_back(mk(0, 1, 5, 1, 2, 3));
    prog.push_back(mk(0, 0, 0, 5, 0, 0));
    idle(4);
    chk("stalled", {31'd0, sb_if.ibuf_ready}, 32'd0);
    cycle(1'b0, 1'b1, 0, 5, 1'b0);
    idle(1);
    cycle(1'b0, 1'b1, 0, 5, 1'b1);
    chk("released", {31'd0, sb_if.ibuf_ready}, 32'd1);
    idle(2);

    phase = "cross_warp";
    prog.push_back(mk(0, 1, 5, 0, 0, 0));
    prog.push_back(mk(1, 0, 0, 5, 0, 0));
    idle(4);
    cycle(1'b0, 1'b1, 0, 5, 1'b1);
    idle(1);

    phase = "x0";
    prog.push_back(mk(1, 1, 0, 0, 0, 0));
    prog.push_back(mk(1, 0, 0, 0, 0, 0));
    idle(4);

    phase = "set_wins";
    prog.push_back(mk(2, 1, 7, 0, 0, 0));
    prog.push_back(mk(2, 0, 0, 7, 0, 0));
    idle(1);
    cycle(1'b0, 1'b1, 2, 7, 1'b1);
    idle(3);
    chk("set_kept", {31'd0, sb_if.ibuf_ready}, 32'd0);
    cycle(1'b0, 1'b1, 2, 7, 1'b1);
    idle(2);

    phase = "rel_err";
    cycle(1'b0, 1'b1, 3, 9, 1'b1);
    idle(3);
    chk("err_sticky", {31'd0, sb_if.release_err}, 32'd1);
    prog.push_back(mk(3, 1, 9, 0, 0, 0));
    prog.push_back(mk(3, 0, 0, 0, 9, 0));
    idle(4);
    cycle(1'b1, 1'b0, 0, 0, 1'b0);
    cycle(1'b1, 1'b0, 0, 0, 1'b0);
    idle(4);

    phase = "random";
    for (int i = 0; i < 400; i++) begin
      if (prog.size() < 2 && $urandom_range(1, 0) == 1)
        prog.push_back(mk($urandom_range(3, 0), $urandom_range(1, 0), $urandom_range(7, 0),
                          $urandom_range(7, 0), $urandom_range(7, 0), $urandom_range(7, 0)));
      if (i % 80 == 79)
        cycle(1'b1, 1'b0, 0, 0, 1'b0);
      else
        cycle(1'b0, $urandom_range(3, 0) != 0, $urandom_range(3, 0), $urandom_range(7, 0),
              $urandom_range(9, 0) < 7);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
